// File: rtl/rx_stream_bridge_pkg.sv
// rtl/rx_stream_bridge_pkg.sv - shared state enum and counter width for rx_stream_bridge
package rx_stream_bridge_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RECE,
        FLUSH
    } state_t;

endpackage

// File: rtl/rx_stream_bridge_if.sv
// rtl/rx_stream_bridge_if.sv - AXI-Stream bundle between the bridge and its sink
interface rx_stream_bridge_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0]   tdata;
    logic                tvalid;
    logic                tready;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;

    modport master (output tdata, output tvalid, output tkeep, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tkeep, input tlast, output tready);
endinterface

// File: rtl/rx_stream_bridge_sync_2ff.sv
// rtl/rx_stream_bridge_sync_2ff.sv - two-flop synchronizer for the RX_REQ toggle
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/rx_stream_bridge.sv
// rtl/rx_stream_bridge.sv - toggle-handshake receiver to AXI-Stream burst bridge
// Optional build macro RX_STREAM_TLAST_EN: hold back newest word and mark burst end with TLAST.
module rx_stream_bridge
    import rx_stream_bridge_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_REQ,
    output logic              RX_ACK,
    rx_stream_bridge_if.master m_axis,
    output logic              RECE_DONE,
    output logic [CNT_W-1:0]  RECE_COUNT,
    output logic [CNT_W-1:0]  BURST_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_TIMEOUT) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_req_sync;
    logic              r_ack;
    logic              w_pending;
    logic              w_full;
    logic              w_wr;
    logic              w_elig;
    logic              w_last;
    logic              w_beat;
    logic              w_flush_done;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_count;
    logic [IW-1:0]     r_idle;
    logic              r_tvalid;
    logic              r_tlast;
    logic [CNT_W-1:0]  r_rece_count;
    logic [CNT_W-1:0]  r_burst_count;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (RX_REQ),
        .o_q (w_req_sync)
    );

    assign w_pending = w_req_sync ^ r_ack;
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr      = w_pending && !w_full && (r_state != FLUSH);
    assign w_beat    = r_tvalid && m_axis.tready;

`ifdef RX_STREAM_TLAST_EN
    // While receiving, the newest word stays buffered so it can later carry TLAST.
    assign w_elig       = (r_state == FLUSH) ? (w_count >= (AW+1)'(1)) : (w_count >= (AW+1)'(2));
    assign w_last       = (r_state == FLUSH) && (w_count == (AW+1)'(1));
    assign w_flush_done = w_beat && r_tlast;
`else
    assign w_elig       = (w_count != '0);
    assign w_last       = 1'b0;
    assign w_flush_done = (w_count == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_wr) w_state_nxt = RECE;
            RECE:    if (r_idle == IW'(IDLE_TIMEOUT - 1)) w_state_nxt = FLUSH;
            FLUSH:   if (w_flush_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Storage has no reset; emptiness is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= RX_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack         <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_idle        <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_rece_count  <= '0;
            r_burst_count <= '0;
        end else begin
            if (w_wr) begin
                r_ack    <= ~r_ack;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_beat) r_rd_ptr <= r_rd_ptr + 1'b1;

            if (r_state == RECE && !w_pending && w_state_nxt == RECE) r_idle <= r_idle + 1'b1;
            else                                                      r_idle <= '0;

            // The head word is presented in place; it leaves the FIFO only on handshake.
            if (w_beat) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end else if (!r_tvalid && w_elig) begin
                r_tvalid <= 1'b1;
                r_tlast  <= w_last;
            end

            if (r_state == IDLE && w_wr) r_rece_count <= '0;
            else if (w_beat)             r_rece_count <= r_rece_count + 1'b1;

            if (r_state == FLUSH && w_state_nxt == IDLE) r_burst_count <= r_burst_count + 1'b1;
        end
    end

    assign RX_ACK        = r_ack;
    assign m_axis.tdata  = r_tvalid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tkeep  = '1;
    assign m_axis.tlast  = r_tlast;
    assign RECE_DONE     = (r_state == IDLE);
    assign RECE_COUNT    = r_rece_count;
    assign BURST_COUNT   = r_burst_count;
endmodule

// File: doc/rx_stream_bridge.md
RX_STREAM_BRIDGE -- requirements
Module: rx_stream_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_W, default 16, SHALL set the data width in bits; it SHALL be a multiple of 8.
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL set the word buffer depth; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter IDLE_TIMEOUT, default 100, SHALL set the number of idle cycles that end a burst; it SHALL be at least 2.
REQ-005 Port clk, input, 1 bit: clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port RX_DATA, input, DATA_W bits: sender data, stable while RX_REQ != RX_ACK.
REQ-008 Port RX_REQ, input, 1 bit: asynchronous toggle request; each toggle offers one word.
REQ-009 Port RX_ACK, output, 1 bit: toggle acknowledge.
REQ-010 Port M_AXIS_TREADY, input, 1 bit: sink ready.
REQ-011 Ports M_AXIS_TDATA (DATA_W bits), M_AXIS_TVALID (1 bit), M_AXIS_TKEEP (DATA_W/8 bits) and M_AXIS_TLAST (1 bit) SHALL be outputs forming the AXI-Stream master.
REQ-012 Port RECE_DONE, output, 1 bit: no burst in progress.
REQ-013 Port RECE_COUNT, output, 32 bits: words accepted on AXIS in the current or last burst.
REQ-014 Port BURST_COUNT, output, 32 bits: number of completed bursts since reset.

Function
REQ-015 RX_REQ SHALL pass through a 2-flop synchronizer; pending SHALL be req_sync XOR RX_ACK, so that no toggle is lost.
REQ-016 When pending, the FIFO is not full, and state != FLUSH, RX_DATA SHALL be written to the FIFO and RX_ACK SHALL toggle in the same clock edge.
REQ-017 With the FIFO full, or in FLUSH, RX_ACK SHALL hold, back-pressuring the sender.
REQ-018 The state machine SHALL have three states: IDLE, RECE and FLUSH.
REQ-019 IDLE SHALL go to RECE on the first FIFO write; this edge SHALL also clear RECE_COUNT to 0.
REQ-020 In RECE, the idle counter SHALL clear on any write or while pending, and SHALL increment otherwise.
REQ-021 RECE SHALL go to FLUSH when the idle counter equals IDLE_TIMEOUT-1.
REQ-022 In RECE, a FIFO word SHALL be eligible for output only while FIFO occupancy is at least 2, so the newest word is always held back.
REQ-023 In FLUSH, every remaining word SHALL be eligible, and the final word SHALL carry TLAST=1.
REQ-024 FLUSH SHALL go to IDLE in the cycle the TLAST beat handshakes; BURST_COUNT SHALL increment by 1 in that cycle.
REQ-025 TVALID SHALL stay high until TREADY is sampled high, and TDATA/TLAST SHALL stay stable while TVALID=1 and TREADY=0.
REQ-026 TKEEP SHALL be constant all-ones.
REQ-027 RECE_COUNT SHALL increment on each TVALID&&TREADY beat.
REQ-028 Both 32-bit counters SHALL wrap modulo 2^32.
REQ-029 RECE_DONE SHALL be 1 in IDLE and 0 in RECE and FLUSH.
REQ-030 Latency SHALL be: RX_REQ toggle to FIFO write and RX_ACK toggle in 3 cycles; an eligible head word to TVALID in 1 cycle.
REQ-031 A pending toggle in the same cycle that FLUSH exits SHALL be accepted the following cycle, in IDLE, and SHALL start a new burst.

Reset
REQ-032 Reset SHALL force the following: RX_ACK=0, TVALID=0, TLAST=0, TDATA=0, RECE_DONE=1, RECE_COUNT=0, BURST_COUNT=0, FIFO empty, state IDLE, synchronizer and idle counter 0.
REQ-033 Reset mid-burst SHALL discard all buffered words; the sender SHALL resynchronise against RX_ACK=0.

Configuration
REQ-034 With RX_STREAM_TLAST_EN defined, the block SHALL behave as REQ-022 to REQ-023.
REQ-035 Without RX_STREAM_TLAST_EN, every FIFO word SHALL be eligible at occupancy of at least 1, TLAST SHALL be constant 0, and FLUSH SHALL end when the FIFO is empty and no beat is outstanding.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE, RECE, FLUSH) and the 32-bit counter width constant.
REQ-037 The sub-module sync_2ff SHALL implement the RX_REQ synchronizer; the FIFO SHALL be inline.

Verification
REQ-038 Scenario: 4 toggles carrying 0x1111..0x4444 with TREADY=1 -> 4 beats in order, TLAST only on 0x4444 about 100 cycles after the last toggle, RECE_COUNT=4, BURST_COUNT=1, RECE_DONE returns to 1.
REQ-039 Scenario: TREADY=0 with 20 toggles at FIFO_DEPTH=16 -> RX_ACK stops after 16 toggles, no timeout occurs; on releasing TREADY, all 20 words arrive and TLAST is set on word 20.
REQ-040 Scenario: TREADY toggling 1/0 each cycle -> TDATA/TLAST are stable while stalled, with no duplicated or dropped words.
REQ-041 Scenario: a toggle arriving during FLUSH -> RX_ACK is withheld until IDLE, the word starts burst 2, and BURST_COUNT reaches 2.
REQ-042 Scenario: reset asserted after 3 words -> all outputs take their reset values, RX_ACK=0, and the next burst starts with RECE_COUNT=0.
REQ-043 Scenario: build without RX_STREAM_TLAST_EN, 1 toggle -> beat emitted within 5 cycles, TLAST=0, RECE_DONE=1 after timeout.
